// File: rtl/convo_pixel_writer_if.sv
// convo_pixel_writer_if: accumulator sample stream in, byte write port out
interface convo_pixel_writer_if #(parameter int ACC_W = 32);
    logic [ACC_W-1:0] accum_in;
    logic             accum_valid;
    logic             accum_ready;
    logic [31:0]      wr_addr;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    modport master (
        input  accum_in, accum_valid, wr_ready,
        output accum_ready, wr_addr, wr_data, wr_valid
    );
    modport slave (
        output accum_in, accum_valid, wr_ready,
        input  accum_ready, wr_addr, wr_data, wr_valid
    );
endinterface

// File: rtl/convo_pixel_writer.sv
// convo_pixel_writer: normalise/saturate accumulator sums and write them as BMP bytes,
// channel-planar, including the 4-byte row padding on the first channel pass.
module convo_pixel_writer #(
    parameter int ACC_W = 32,
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      out_base,
    input  logic [DIM_W-1:0] image_width,
    input  logic [DIM_W-1:0] image_height,
    input  logic [4:0]       shift,
    output logic             busy,
    output logic             done,
    convo_pixel_writer_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] PAD   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    logic [2:0]              state;
    logic [31:0]             base, stride, row_base, col_off, addr_q;
    logic [DIM_W-1:0]        w, h, col, row;
    logic [4:0]              sh;
    logic [1:0]              pad, pad_cnt, chan;
    logic [7:0]              data_q, sat;
    logic signed [ACC_W-1:0] v;
    logic [31:0]             in_w3, in_stride;
    logic                    col_end, row_end, last;
    assign in_w3     = {{(32-DIM_W){1'b0}}, image_width} + {{(31-DIM_W){1'b0}}, image_width, 1'b0};
    assign in_stride = (in_w3 + 32'd3) & ~32'd3;
    assign v         = $signed(bus.accum_in) >>> sh;
    assign sat       = v[ACC_W-1] ? 8'h00 : (|v[ACC_W-2:8]) ? 8'hFF : v[7:0];
    assign col_end   = col == DIM_W'(w - 1'b1);
    assign row_end   = row == DIM_W'(h - 1'b1);
    assign last      = chan == 2'd2 && row_end && col_end;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            base     <= '0;
            stride   <= '0;
            row_base <= '0;
            col_off  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            w        <= '0;
            h        <= '0;
            col      <= '0;
            row      <= '0;
            sh       <= '0;
            pad      <= '0;
            pad_cnt  <= '0;
            chan     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base     <= out_base;
                    w        <= image_width;
                    h        <= image_height;
                    sh       <= shift;
                    stride   <= in_stride;
                    pad      <= 2'(in_stride - in_w3);
                    row_base <= out_base;
                    col_off  <= '0;
                    col      <= '0;
                    row      <= '0;
                    chan     <= '0;
                    state    <= (image_width == '0 || image_height == '0) ? DONE : RUN;
                end
                RUN: if (bus.accum_valid) begin
                    addr_q <= row_base + col_off + {30'd0, chan};
                    data_q <= sat;
                    state  <= WRITE;
                end
                WRITE: if (bus.wr_ready) begin
                    // col*3 and row*stride are running sums, so no multiplier is needed
                    if (col_end) begin
                        col     <= '0;
                        col_off <= '0;
                        if (row_end) begin
                            row      <= '0;
                            row_base <= base;
                            chan     <= last ? 2'd0 : chan + 2'd1;
                        end else begin
                            row      <= row + 1'b1;
                            row_base <= row_base + stride;
                        end
                    end else begin
                        col     <= col + 1'b1;
                        col_off <= col_off + 32'd3;
                    end
                    if (chan == 2'd0 && col_end && pad != 2'd0) begin
                        addr_q  <= row_base + col_off + 32'd3;
                        data_q  <= 8'h00;
                        pad_cnt <= '0;
                        state   <= PAD;
                    end else begin
                        state <= last ? DONE : RUN;
                    end
                end
                PAD: if (bus.wr_ready) begin
                    if (pad_cnt == pad - 2'd1) begin
                        state <= RUN;
                    end else begin
                        pad_cnt <= pad_cnt + 2'd1;
                        addr_q  <= addr_q + 32'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.accum_ready = state == RUN;
    assign bus.wr_valid    = state == WRITE || state == PAD;
    assign bus.wr_addr     = addr_q;
    assign bus.wr_data     = data_q;
    assign busy            = state != IDLE;
    assign done            = state == DONE;
endmodule

// File: tb/tb_convo_pixel_writer.sv
// tb_convo_pixel_writer: scoreboard bench; expected bytes are queued by a reference model
// when a job starts and popped by the write-port monitor.
module tb_convo_pixel_writer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] out_base = '0;
    logic [15:0] image_width = '0;
    logic [15:0] image_height = '0;
    logic [4:0]  shift = '0;
    logic        busy, done;
    int          total = 0;
    int          bad = 0;
    int          rdy_mode = 0;
    logic [39:0] exp_q[$];
    logic [39:0] exp_e;
    int          smp[$];

    convo_pixel_writer_if ifc();

    convo_pixel_writer dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .out_base(out_base),
        .image_width(image_width),
        .image_height(image_height),
        .shift(shift),
        .busy(busy),
        .done(done),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ifc.wr_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && ifc.wr_valid === 1'b1 && ifc.wr_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got %h:%h required no write", ifc.wr_addr, ifc.wr_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({ifc.wr_addr, ifc.wr_data} !== exp_e) begin
                    bad++;
                    $display("FAIL write: got %h:%h required %h:%h", ifc.wr_addr, ifc.wr_data, exp_e[39:8], exp_e[7:0]);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] b, input int w, input int h, input int sh);
        int stride = (3 * w + 3) & ~3;
        int i = 0;
        int v;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < h; r++) begin
                for (int x = 0; x < w; x++) begin
                    v = smp[i] >>> sh;
                    i++;
                    exp_q.push_back({b + 32'(r * stride + x * 3 + c), v < 0 ? 8'h00 : v > 255 ? 8'hFF : 8'(v)});
                end
                if (c == 0)
                    for (int p = 0; p < stride - 3 * w; p++)
                        exp_q.push_back({b + 32'(r * stride + 3 * w + p), 8'h00});
            end
    endtask

    task automatic fill(input int n, input int lo, input int hi);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(int'($urandom_range(0, hi - lo)) + lo);
    endtask

    task automatic pulse_start(input logic [31:0] b, input int w, input int h, input int sh);
        @(posedge clk);
        #1;
        out_base     = b;
        image_width  = 16'(w);
        image_height = 16'(h);
        shift        = 5'(sh);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic begin_job(input logic [31:0] b, input int w, input int h, input int sh);
        push_exp(b, w, h, sh);
        pulse_start(b, w, h, sh);
    endtask

    task automatic feed(input int v);
        bit ok = 0;
        ifc.accum_valid = 1'b1;
        ifc.accum_in    = v;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = ifc.accum_ready;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got accum_ready=0 required 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        ifc.accum_valid = 1'b0;
    endtask

    task automatic feed_from(input int i0);
        for (int i = i0; i < smp.size(); i++) feed(smp[i]);
    endtask

    task automatic finish_job(input string name);
        bit got = 0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            got = done;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_done: got no done pulse required one", name);
        end
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL %s_idle: got busy/done=%b%b required 00", name, busy, done);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: got %0d writes outstanding required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, ifc.accum_ready, ifc.wr_valid} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 0000", {busy, done, ifc.accum_ready, ifc.wr_valid});
        end
        total++;
        if ({ifc.wr_addr, ifc.wr_data} !== 40'd0) begin
            bad++;
            $display("FAIL reset_bus: got %h:%h required 0:0", ifc.wr_addr, ifc.wr_data);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        smp = '{10, 300, -5, 255, 0, 128};
        begin_job(32'h1000, 2, 1, 0);
        feed_from(0);
        finish_job("basic");
    endtask

    task automatic test_saturate();
        smp = '{32'h0FF0, 32'h1000, 32'hFFFFFF00, 32'h50, 16, 4095, -1, 4096, 0, 15, 17, 32'h7FFFFFFF};
        begin_job(32'h1100, 4, 1, 4);
        feed_from(0);
        finish_job("saturate");
    endtask

    task automatic test_stall();
        logic [39:0] held;
        rdy_mode = 2;
        smp = '{20, 40, 60, 80, 100, 120};
        begin_job(32'h1200, 2, 1, 0);
        feed(smp[0]);
        @(negedge clk);
        total++;
        if (ifc.wr_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_latency: got wr_valid=%b required 1", ifc.wr_valid);
        end
        held = {ifc.wr_addr, ifc.wr_data};
        ifc.accum_valid = 1'b1;
        ifc.accum_in    = smp[1];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({ifc.wr_valid, ifc.accum_ready, ifc.wr_addr, ifc.wr_data} !== {2'b10, 40'h000000120014}) begin
                bad++;
                $display("FAIL stall_hold: got %b%b %h:%h required 10 00001200:14",
                         ifc.wr_valid, ifc.accum_ready, ifc.wr_addr, ifc.wr_data);
            end
        end
        total++;
        if (held !== 40'h000000120014) begin
            bad++;
            $display("FAIL stall_first: got %h required 00001200:14", held);
        end
        rdy_mode = 0;
        feed_from(1);
        finish_job("stall");
    endtask

    task automatic test_geometry();
        fill(24, -100, 400);
        begin_job(32'h2000, 4, 2, 0);
        feed_from(0);
        finish_job("geom_w4");
        fill(6, 0, 255);
        begin_job(32'h3001, 1, 2, 0);
        feed_from(0);
        finish_job("geom_w1");
    endtask

    task automatic test_reset_mid();
        fill(24, 0, 255);
        begin_job(32'h4000, 4, 2, 0);
        feed(smp[0]);
        feed(smp[1]);
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, ifc.accum_ready, ifc.wr_valid} !== 4'b0) begin
            bad++;
            $display("FAIL midreset_ctrl: got %b required 0000", {busy, done, ifc.accum_ready, ifc.wr_valid});
        end
        total++;
        if ({ifc.wr_addr, ifc.wr_data} !== 40'd0) begin
            bad++;
            $display("FAIL midreset_bus: got %h:%h required 0:0", ifc.wr_addr, ifc.wr_data);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        fill(24, -50, 600);
        begin_job(32'h5000, 4, 2, 1);
        feed_from(0);
        finish_job("after_reset");
    endtask

    task automatic test_start_busy();
        fill(12, 0, 2000);
        begin_job(32'h6000, 2, 2, 2);
        feed(smp[0]);
        feed(smp[1]);
        feed(smp[2]);
        pulse_start(32'h7000, 5, 5, 0);
        feed_from(3);
        finish_job("start_busy");
        pulse_start(32'h8000, 0, 3, 0);
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b11) begin
            bad++;
            $display("FAIL zero_w_done: got busy/done=%b%b required 11", busy, done);
        end
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL zero_w_pulse: got busy/done=%b%b required 00", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        rdy_mode = 1;
        fill(18, -2000, 5000);
        begin_job(32'h9000, 3, 2, 3);
        feed_from(0);
        finish_job("b2b_w3");
        fill(45, -10, 300);
        begin_job(32'hA002, 5, 3, 0);
        feed_from(0);
        finish_job("b2b_w5");
        rdy_mode = 0;
    endtask

    initial begin
        ifc.accum_valid = 1'b0;
        ifc.accum_in    = '0;
        test_reset();
        test_basic();
        test_saturate();
        test_stall();
        test_geometry();
        test_reset_mid();
        test_start_busy();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
